cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_result_fifo.sv | 49 ++++
 rtl/cdb_arbiter.sv | 115 +++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB packet type and sizing helpers for the common-data-bus arbiter.
// ROB_TAG_LEN / XLEN default here when no project-wide sys_defs.svh has set them.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

package cdb_arbiter_pkg;

  typedef struct packed {
    logic [`ROB_TAG_LEN-1:0] tag;
    logic [`XLEN-1:0]        value;
  } CDB_PACKET;

  // Index width that never collapses to zero bits for single-entry sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer: FIFO_DEPTH {tag, value} entries, wrapping pointers, occupancy count.
module cdb_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  CDB_PACKET din,
  output CDB_PACKET dout,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = idx_w(FIFO_DEPTH);

  CDB_PACKET        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: per-FU result FIFOs feeding one registered wakeup broadcast.
// Optional macro CDB_BYPASS_EN lets an empty FU's incoming result win arbitration directly.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_FU-1:0]                   fu_valid,
  input  logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0] fu_tag,
  input  logic [NUM_FU-1:0][`XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]                   fu_stall,
  output logic                                wakeup,
  output logic [`ROB_TAG_LEN-1:0]             wakeup_tag,
  output logic [`XLEN-1:0]                    wakeup_value
);

  localparam int IDX_W = idx_w(NUM_FU);

  CDB_PACKET         w_din  [NUM_FU];
  CDB_PACKET         w_dout [NUM_FU];
  logic [NUM_FU-1:0] w_empty;
  logic [NUM_FU-1:0] w_full;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_bypass;
  logic              w_grant_vld_p0;
  logic [IDX_W-1:0]  w_grant_idx_p0;
  logic [IDX_W:0]    w_scan;
  logic [IDX_W-1:0]  w_next_ptr;
  CDB_PACKET         w_sel_pkt_p0;

  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_vld_p1;
  CDB_PACKET         r_pkt_p1;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign w_din[gi] = '{tag: fu_tag[gi], value: fu_value[gi]};

    cdb_result_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[gi]),
      .pop   (w_pop[gi]),
      .din   (w_din[gi]),
      .dout  (w_dout[gi]),
      .empty (w_empty[gi]),
      .full  (w_full[gi])
    );
  end

  always_comb begin
`ifdef CDB_BYPASS_EN
    w_req = ~w_empty | (fu_valid & {NUM_FU{reset}});
`else
    w_req = ~w_empty;
`endif
  end

  // Scan from the pointer downward in distance so the closest requester wins last.
  always_comb begin
    w_grant_vld_p0 = 1'b0;
    w_grant_idx_p0 = '0;
    w_scan         = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_scan >= (IDX_W+1)'(NUM_FU)) w_scan = w_scan - (IDX_W+1)'(NUM_FU);
      if (w_req[w_scan[IDX_W-1:0]]) begin
        w_grant_vld_p0 = 1'b1;
        w_grant_idx_p0 = w_scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_bypass = '0;
    w_pop    = '0;
`ifdef CDB_BYPASS_EN
    if (w_grant_vld_p0 && w_empty[w_grant_idx_p0]) w_bypass[w_grant_idx_p0] = 1'b1;
    w_sel_pkt_p0 = w_empty[w_grant_idx_p0] ? w_din[w_grant_idx_p0] : w_dout[w_grant_idx_p0];
`else
    w_sel_pkt_p0 = w_dout[w_grant_idx_p0];
`endif
    if (w_grant_vld_p0 && !w_empty[w_grant_idx_p0]) w_pop[w_grant_idx_p0] = 1'b1;
    w_push = fu_valid & ~w_full & ~w_bypass & {NUM_FU{reset}};
  end

  assign w_next_ptr = (w_grant_idx_p0 == IDX_W'(NUM_FU - 1)) ? '0 : w_grant_idx_p0 + 1'b1;

  // p0 -> p1: grant result registered onto the broadcast bus
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_vld_p1 <= 1'b0;
      r_pkt_p1 <= '0;
    end else begin
      r_vld_p1 <= w_grant_vld_p0;
      if (w_grant_vld_p0) begin
        r_pkt_p1 <= w_sel_pkt_p0;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign fu_stall     = w_full;
  assign wakeup       = r_vld_p1;
  assign wakeup_tag   = r_pkt_p1.tag;
  assign wakeup_value = r_pkt_p1.value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-level reference model predicts every broadcast.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NFU   = 2;
  localparam int DEPTH = 2;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [NFU-1:0]                   fu_valid;
  logic [NFU-1:0][`ROB_TAG_LEN-1:0] fu_tag;
  logic [NFU-1:0][`XLEN-1:0]        fu_value;
  logic [NFU-1:0]                   fu_stall;
  logic                             wakeup;
  logic [`ROB_TAG_LEN-1:0]          wakeup_tag;
  logic [`XLEN-1:0]                 wakeup_value;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NFU), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .fu_valid     (fu_valid),
    .fu_tag       (fu_tag),
    .fu_value     (fu_value),
    .fu_stall     (fu_stall),
    .wakeup       (wakeup),
    .wakeup_tag   (wakeup_tag),
    .wakeup_value (wakeup_value)
  );

  CDB_PACKET src [NFU][$];
  CDB_PACKET mq  [NFU][$];
  CDB_PACKET exp_q[$];
  int        rr;
  bit        m_wv;
  CDB_PACKET m_last;
  bit        started;
  int        n_chk  = 0;
  int        n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  function automatic CDB_PACKET mk(input int t, input int v);
    CDB_PACKET p;
    p.tag   = (`ROB_TAG_LEN)'(t);
    p.value = (`XLEN)'(v);
    return p;
  endfunction

  // Reference: FIFO queues, round-robin from the slot after the last winner, one broadcast per edge.
  task automatic model_edge(input bit rst_n);
    bit        acc [NFU];
    bit        byp [NFU];
    int        g;
    CDB_PACKET pin [NFU];
    if (!rst_n) begin
      started = 1'b1;
      for (int i = 0; i < NFU; i++) mq[i].delete();
      exp_q.delete();
      rr     = 0;
      m_wv   = 1'b0;
      m_last = '0;
      return;
    end
    for (int i = 0; i < NFU; i++) begin
      acc[i] = fu_valid[i] && (mq[i].size() != DEPTH);
      byp[i] = 1'b0;
      pin[i] = mk(int'(fu_tag[i]), int'(fu_value[i]));
    end
    g = -1;
    for (int k = 0; k < NFU; k++) begin
      int i;
      i = (rr + k) % NFU;
`ifdef CDB_BYPASS_EN
      if (g < 0 && (mq[i].size() > 0 || acc[i])) g = i;
`else
      if (g < 0 && mq[i].size() > 0) g = i;
`endif
    end
    if (g >= 0) begin
      CDB_PACKET p;
      if (mq[g].size() > 0) p = mq[g].pop_front();
      else begin
        p      = pin[g];
        byp[g] = 1'b1;
      end
      exp_q.push_back(p);
      m_wv   = 1'b1;
      m_last = p;
      rr     = (g + 1) % NFU;
    end else begin
      m_wv = 1'b0;
    end
    for (int i = 0; i < NFU; i++) begin
      if (acc[i] && !byp[i]) mq[i].push_back(pin[i]);
      if (acc[i]) void'(src[i].pop_front());
    end
  endtask

  task automatic step(input bit rst_n);
    @(negedge clk);
    reset = rst_n;
    for (int i = 0; i < NFU; i++) begin
      if (src[i].size() > 0) begin
        fu_valid[i] = 1'b1;
        fu_tag[i]   = src[i][0].tag;
        fu_value[i] = src[i][0].value;
      end else begin
        fu_valid[i] = 1'b0;
        fu_tag[i]   = (`ROB_TAG_LEN)'($urandom);
        fu_value[i] = (`XLEN)'($urandom);
      end
    end
    #1;
    for (int i = 0; i < NFU; i++)
      check($sformatf("stall%0d", i), fu_stall[i], mq[i].size() == DEPTH);
    @(posedge clk);
    model_edge(rst_n);
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step(1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("wakeup", wakeup, m_wv);
        if (wakeup) begin
          check("sb_has_entry", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            CDB_PACKET p;
            p = exp_q.pop_front();
            check("bcast_tag", wakeup_tag, p.tag);
            check("bcast_value", wakeup_value, p.value);
          end
        end
        check("hold_tag", wakeup_tag, m_last.tag);
        check("hold_value", wakeup_value, m_last.value);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;
    rr       = 0;
    m_wv     = 1'b0;
    m_last   = '0;
    started  = 1'b0;

    // Reset held with both FUs presenting: nothing accepted, nothing broadcast after release.
    src[0].push_back(mk(11, 32'hAAAA));
    src[1].push_back(mk(12, 32'hBBBB));
    repeat (3) step(1'b0);
    for (int i = 0; i < NFU; i++) src[i].delete();
    steps(3);

    // Single result through the buffer.
    src[0].push_back(mk(5, 32'h1234));
    steps(4);

    // Same-edge pair, then again after an idle cycle.
    src[0].push_back(mk(3, 32'h3333));
    src[1].push_back(mk(7, 32'h7777));
    steps(4);
    src[0].push_back(mk(3, 32'h3030));
    src[1].push_back(mk(7, 32'h7070));
    steps(4);

    // FU 0 floods while FU 1 sends three ordered results.
    for (int t = 20; t < 26; t++) src[0].push_back(mk(t, t * 16));
    for (int t = 1; t <= 3; t++)  src[1].push_back(mk(t, t + 32'h100));
    steps(14);

    // Reset with buffers loaded.
    for (int t = 0; t < 6; t++) begin
      src[0].push_back(mk(40 + t, 32'h4000 + t));
      src[1].push_back(mk(50 + t, 32'h5000 + t));
    end
    steps(3);
    step(1'b0);
    for (int i = 0; i < NFU; i++) src[i].delete();
    steps(3);

`ifdef CDB_BYPASS_EN
    // Idle arbiter: a single result should appear one edge later.
    src[0].push_back(mk(9, 32'h9999));
    steps(3);
`endif

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NFU; i++)
        if (src[i].size() < 3 && $urandom_range(0, 1) == 1)
          src[i].push_back(mk(int'($urandom_range(0, (1 << `ROB_TAG_LEN) - 1)), int'($urandom)));
      step($urandom_range(0, 49) != 0);
    end

    for (int i = 0; i < NFU; i++) src[i].delete();
    steps(10);
    check("drained", exp_q.size() + mq[0].size() + mq[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
